// File: rtl/data_mem_ctrl.sv
// Byte/halfword/word data memory controller with a fixed wait-state count and a one-cycle ack.
// Define DMEM_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into error responses.
`timescale 1ns/1ps

module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            mode,
    input  logic                  sign,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic                  err
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  commit;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [1:0]            mode_q;
    logic                  sign_q;
    logic [31:0]           wdata_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] op_addr;
    logic                  op_wr;
    logic [1:0]            op_mode;
    logic                  op_sign;
    logic [31:0]           op_wdata;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [31:0]           rd_word;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_val;
    logic                  misalign;
    logic                  bad;

    logic [31:0]           mem [DEPTH];

    // With zero wait states the commit edge is the accept edge, so the live inputs are used there
    assign op_addr  = (state == S_IDLE) ? addr  : addr_q;
    assign op_wr    = (state == S_IDLE) ? wr    : wr_q;
    assign op_mode  = (state == S_IDLE) ? mode  : mode_q;
    assign op_sign  = (state == S_IDLE) ? sign  : sign_q;
    assign op_wdata = (state == S_IDLE) ? wdata : wdata_q;
    assign word_idx = op_addr[ADDR_WIDTH-1:2];
    assign rd_word  = mem[word_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((op_mode == 2'b01) && op_addr[0]) ||
                      ((op_mode == 2'b10) && (op_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad = (op_mode == 2'b11) || misalign;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lane steering: stores replicate data across lanes, loads pull the addressed lane down to bit 0
    always_comb begin
        be       = 4'b0000;
        wlanes   = op_wdata;
        byte_sel = rd_word[{op_addr[1:0], 3'b000} +: 8];
        half_sel = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'd0;
        case (op_mode)
            2'b00: begin
                be       = 4'b0001 << op_addr[1:0];
                wlanes   = {4{op_wdata[7:0]}};
                load_val = {{24{op_sign & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be       = op_addr[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{op_wdata[15:0]}};
                load_val = {{16{op_sign & half_sel[15]}}, half_sel};
            end
            2'b10: begin
                be       = 4'b1111;
                load_val = rd_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            mode_q  <= 2'b00;
            sign_q  <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if ((state == S_IDLE) && req) begin
                addr_q  <= addr;
                wr_q    <= wr;
                mode_q  <= mode;
                sign_q  <= sign;
                wdata_q <= wdata;
            end
            if (commit) begin
                err_q <= bad;
                rdata <= (bad || op_wr) ? 32'd0 : load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (commit && op_wr && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    assign ack = (state == S_RESP);
    assign err = ack & err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: byte-array reference model, randomized accesses,
// plus a zero-wait-state instance exercised with a few directed accesses.
`timescale 1ns/1ps

module tb_data_mem_ctrl;

    localparam int AW = 12;
    localparam int WS = 1;

    logic          clk = 1'b0;
    logic          clr;
    logic          req, wr, sign;
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack, err;

    logic          req0, wr0, sign0;
    logic [1:0]    mode0;
    logic [AW-1:0] addr0;
    logic [31:0]   wdata0;
    logic [31:0]   rdata0;
    logic          ack0, err0;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .clr(clr), .req(req), .wr(wr), .mode(mode), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err)
    );

    data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_zw (
        .clk(clk), .clr(clr), .req(req0), .wr(wr0), .mode(mode0), .sign(sign0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ack(ack0), .err(err0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          test_count = 0;
    int          fail_count = 0;
    logic [7:0]  ref_bytes [0:(1<<AW)-1];
    logic [31:0] last_rdata = 32'd0;
    int          next_free = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        test_count++;
        if (act !== exp_v) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Memory viewed as little-endian bytes; naturally aligned base, arithmetic sign extension
    function automatic void modelAccess(input logic w, input logic [1:0] m, input logic s,
                                        input logic [AW-1:0] a, input logic [31:0] d,
                                        output logic [31:0] er, output logic ee);
        int     n, base;
        longint val;
        ee = (m == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (m == 2'b01 && (a % 2) != 0) ee = 1'b1;
        if (m == 2'b10 && (a % 4) != 0) ee = 1'b1;
`endif
        er = 32'd0;
        if (ee) return;
        n    = 1 << m;
        base = int'(a) - (int'(a) % n);
        if (w) begin
            for (int i = 0; i < n; i++) ref_bytes[base+i] = 8'(d >> (8*i));
        end else begin
            val = 0;
            for (int i = 0; i < n; i++) val += longint'(ref_bytes[base+i]) << (8*i);
            if (s && n < 4 && val >= (longint'(1) << (8*n-1))) val -= longint'(1) << (8*n);
            er = 32'(val);
        end
    endfunction

    task automatic scrambleInputs();
        wr    = 1'($urandom);
        mode  = 2'($urandom);
        sign  = 1'($urandom);
        addr  = AW'($urandom);
        wdata = $urandom;
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] m, input logic s,
                                 input logic [AW-1:0] a, input logic [31:0] d, input int hold);
        exp_t        e;
        logic [31:0] er;
        logic        ee;
        int          k;
        while (cyc < next_free) @(negedge clk);
        k = cyc;
        req = 1'b1; wr = w; mode = m; sign = s; addr = a; wdata = d;
        modelAccess(w, m, s, a, d, er, ee);
        e.cyc = k + 1 + WS; e.rdata = er; e.err = ee;
        sb.push_back(e);
        if (hold > WS + 2) hold = WS + 2;
        for (int j = 1; j < hold; j++) begin
            @(negedge clk);
            scrambleInputs();
        end
        @(negedge clk);
        req = 1'b0;
        scrambleInputs();
        next_free = k + WS + 2;
    endtask

    task automatic pulseClear();
        #2;
        clr = 1'b1;
        sb.delete();
        last_rdata = 32'd0;
        foreach (ref_bytes[i]) ref_bytes[i] = 8'd0;
        #1;
        checkOutput("clr_ack", 32'(ack), 32'd0);
        checkOutput("clr_rdata", rdata, 32'd0);
        #1;
        clr = 1'b0;
        @(negedge clk);
        next_free = cyc;
    endtask

    task automatic zeroWaitCheck(input logic w, input logic [1:0] m, input logic s,
                                 input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req0 = 1'b1; wr0 = w; mode0 = m; sign0 = s; addr0 = a; wdata0 = d;
        @(negedge clk);
        req0 = 1'b0;
        checkOutput("zw_ack", 32'(ack0), 32'd1);
        checkOutput("zw_rdata", rdata0, exp_rd);
        checkOutput("zw_err", 32'(err0), 32'(exp_err));
        @(negedge clk);
        checkOutput("zw_ack_drop", 32'(ack0), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every ack, enforces rdata hold and ack deadlines otherwise
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                test_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_ack: got ack=1, expected no response (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                checkOutput("rdata", rdata, mon_e.rdata);
                checkOutput("err", 32'(err), 32'(mon_e.err));
                last_rdata = mon_e.rdata;
            end
        end else begin
            checkOutput("rdata_hold", rdata, last_rdata);
            if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                mon_e = sb.pop_front();
                test_count++;
                fail_count++;
                $display("[TB] FAIL missing_ack: got ack=0, expected ack at cycle %0d (cycle %0d)", mon_e.cyc, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        clr = 1'b1;
        req = 1'b0; wr = 1'b0; mode = 2'b00; sign = 1'b0; addr = '0; wdata = 32'd0;
        req0 = 1'b0; wr0 = 1'b0; mode0 = 2'b00; sign0 = 1'b0; addr0 = '0; wdata0 = 32'd0;
        foreach (ref_bytes[i]) ref_bytes[i] = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        clr = 1'b0;
        @(negedge clk);
        next_free = cyc;

        applyStimulus(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1);
        applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1);
        applyStimulus(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 2);
        applyStimulus(1'b1, 2'b00, 1'b0, 12'h013, 32'h00000080, 1);
        applyStimulus(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, 1);
        applyStimulus(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, 1);
        applyStimulus(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1);
        applyStimulus(1'b1, 2'b10, 1'b0, 12'h021, 32'h12345678, 1);
        applyStimulus(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 1);
        applyStimulus(1'b0, 2'b11, 1'b0, 12'h040, 32'h0, WS + 2);
        applyStimulus(1'b1, 2'b10, 1'b0, 12'h030, 32'hAAAA5555, 1);
        pulseClear();
        applyStimulus(1'b0, 2'b10, 1'b0, 12'h030, 32'h0, 1);

        repeat (300) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) next_free += $urandom_range(1, 3);
            applyStimulus(1'($urandom), (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
                          1'($urandom), AW'($urandom_range(0, 63)), $urandom,
                          $urandom_range(1, WS + 2));
        end

        repeat (WS + 4) @(negedge clk);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        zeroWaitCheck(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
        zeroWaitCheck(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0);
        zeroWaitCheck(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
        zeroWaitCheck(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 32'h00000000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
